// File: rtl/image_downsample.sv
// Crops a 448x448 window from a 640x480 grayscale stream and reduces it to a
// 28x28 image by averaging 16x16 blocks, writing one byte per block.
module image_downsample #(
  parameter int X0     = 96,
  parameter int Y0     = 16,
  parameter bit INVERT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [7:0] pix_gray,
  output logic       img_we,
  output logic [9:0] img_waddr,
  output logic [7:0] img_wdata,
  output logic       busy,
  output logic       done
);

  localparam int WIN       = 448;
  localparam int BLOCKS    = 28;
  localparam int LAST_ADDR = BLOCKS * BLOCKS - 1;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] px_ext, py_ext, dx, dy;
  logic        in_win, hit, first_pix, last_pix, we_d;
  logic [4:0]  bc, br;
  logic [15:0] acc_q [BLOCKS];
  logic [15:0] acc_sel, sum;
  logic [7:0]  avg, wdata_d;
  logic [9:0]  waddr_d;
  logic        img_we_q;
  logic [9:0]  img_waddr_q;
  logic [7:0]  img_wdata_q;

  // Window-relative coordinates; the unsigned compares reject both sides.
  assign px_ext    = {1'b0, pix_x};
  assign py_ext    = {1'b0, pix_y};
  assign dx        = px_ext - 11'(X0);
  assign dy        = py_ext - 11'(Y0);
  assign in_win    = (px_ext >= 11'(X0)) && (dx < 11'(WIN)) &&
                     (py_ext >= 11'(Y0)) && (dy < 11'(WIN));
  assign hit       = pix_valid && in_win && (state_q == CAPTURE);
  assign bc        = dx[8:4];
  assign br        = dy[8:4];
  assign first_pix = (dx[3:0] == 4'd0) && (dy[3:0] == 4'd0);
  assign last_pix  = (&dx[3:0]) && (&dy[3:0]);

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < BLOCKS; i++)
      if (bc == 5'(i)) acc_sel = acc_q[i];
  end

  // The block's top-left pixel restarts the sum, which also flushes stale data
  // left by an aborted frame.
  assign sum     = (first_pix ? 16'd0 : acc_sel) + {8'd0, pix_gray};
  assign avg     = sum[15:8];
  assign we_d    = hit && last_pix;
  assign waddr_d = {5'd0, br} * 10'd28 + {5'd0, bc};
  assign wdata_d = INVERT ? (8'd255 - avg) : avg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCKS; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < BLOCKS; i++)
        if (hit && (bc == 5'(i))) acc_q[i] <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_we_q    <= 1'b0;
      img_waddr_q <= '0;
      img_wdata_q <= '0;
    end else begin
      img_we_q <= we_d;
      if (we_d) begin
        img_waddr_q <= waddr_d;
        img_wdata_q <= wdata_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A frame_start while capturing simply keeps us in CAPTURE; the
  // top-left load rule restarts every block.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_d = CAPTURE;
      CAPTURE:    if (img_we_q && (img_waddr_q == 10'(LAST_ADDR))) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign img_we    = img_we_q;
  assign img_waddr = img_waddr_q;
  assign img_wdata = img_wdata_q;
  assign busy      = (state_q == WAIT_FRAME) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_image_downsample.sv
// Randomized bench for image_downsample: sparse/full block scans against a
// per-block averaging reference model with an expected-write queue.
module tb_image_downsample;

  localparam int X0  = 96;
  localparam int Y0  = 16;
  localparam bit INV = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [7:0] pix_gray = '0;
  logic       img_we;
  logic [9:0] img_waddr;
  logic [7:0] img_wdata;
  logic       busy;
  logic       done;

  image_downsample #(.X0(X0), .Y0(Y0), .INVERT(INV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_gray(pix_gray),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  write_cnt = 0;
  int  done_cnt = 0;
  int  frame_writes = 0;
  int  m_state = 0;          // 0 idle, 1 waiting for frame, 2 capturing
  int  bsum [784];
  int  got_mem [1024];
  bit  prev_w783 = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each 16x16 block sums the pixels seen since its top-left pixel.
  task automatic model_pixel(input int x, input int y, input int g);
    int dx, dy, b, avg;
    dx = x - X0;
    dy = y - Y0;
    if (dx < 0 || dx >= 448 || dy < 0 || dy >= 448) return;
    b = (dy / 16) * 28 + dx / 16;
    if (dx % 16 == 0 && dy % 16 == 0) bsum[b] = g;
    else bsum[b] += g;
    if (dx % 16 == 15 && dy % 16 == 15) begin
      avg = bsum[b] / 256;
      exp_q.push_back('{addr: b, data: INV ? 255 - avg : avg});
      frame_writes++;
      if (b == 783) m_state = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit fs, input bit v,
                       input int x, input int y, input int g);
    start = st; frame_start = fs; pix_valid = v;
    pix_x = 10'(x); pix_y = 10'(y); pix_gray = 8'(g);
    if (v && m_state == 2) model_pixel(x, y, g);
    if (st && m_state == 0) m_state = 1;
    else if (fs && m_state == 1) m_state = 2;
    cycle();
    start = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
  endtask

  function automatic int gray_of(input int mode, input int x, input int y);
    case (mode)
      0: return 200;
      1: return x & 255;
      2: return int'($urandom_range(0, 255));
      default: begin
        if (x == X0 + 5 && y == Y0 + 5) return 255;
        if (x >= X0 + 48 && x < X0 + 64 && y >= Y0 && y < Y0 + 16) return 255;
        return 0;
      end
    endcase
  endfunction

  // Raster scan: block row full_br fully, other rows only at offsets needed
  // to load/finish each block plus one random column.
  task automatic send_frame(input int mode, input int full_br, input int stop_at);
    int coff, x, y;
    coff = int'($urandom_range(1, 14));
    frame_writes = 0;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, X0 + 15, Y0 - 1, 77);
    for (int br = 0; br < 28; br++) begin
      for (int ro = 0; ro < 16; ro++) begin
        if (br != full_br && ro != 0 && ro != 15) continue;
        y = Y0 + br * 16 + ro;
        drive(0, 0, 1, X0 - 1, y, gray_of(2, 0, 0));
        for (int bc = 0; bc < 28; bc++) begin
          for (int co = 0; co < 16; co++) begin
            if (br != full_br && co != 0 && co != coff && co != 15) continue;
            x = X0 + bc * 16 + co;
            drive(0, 0, 1, x, y, gray_of(mode, x, y));
            if (stop_at > 0 && frame_writes >= stop_at) return;
          end
        end
        drive(0, 0, 1, X0 + 448, y, gray_of(2, 0, 0));
      end
    end
    drive(0, 0, 1, X0 + 15, Y0 + 448, 255);
    drive(0, 0, 1, X0 + 447, Y0 + 448, 255);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (prev_w783) check_val("done_after_783", int'(done), 1);
    else if (done) check_val("done_spurious", int'(done), 0);
    if (done) done_cnt++;
    if (img_we) begin
      write_cnt++;
      got_mem[img_waddr] = int'(img_wdata);
      if (exp_q.size() == 0) check_val("unexpected_write", int'(img_we), 0);
      else begin
        e = exp_q.pop_front();
        check_val("waddr", int'(img_waddr), e.addr);
        check_val("wdata", int'(img_wdata), e.data);
      end
    end
    prev_w783 = img_we && (img_waddr == 10'd783);
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"}, int'(img_we), 0);
    check_val({tag, "_waddr"}, int'(img_waddr), 0);
    check_val({tag, "_wdata"}, int'(img_wdata), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run_capture(input string name, input int mode, input int full_br);
    int w0, d0;
    w0 = write_cnt; d0 = done_cnt;
    drive(1, 0, 0, 0, 0, 0);
    check_val({name, "_busy_wait"}, int'(busy), 1);
    send_frame(mode, full_br, 0);
    check_val({name, "_writes"}, write_cnt - w0, 784);
    check_val({name, "_dones"}, done_cnt - d0, 1);
    check_val({name, "_busy_end"}, int'(busy), 0);
    $display("capture %s: writes=%0d dones=%0d", name, write_cnt - w0, done_cnt - d0);
  endtask

  initial begin
    int w0, d0, cnt55;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycle();

    // frame_start with no start: nothing happens
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 1, X0 + i, Y0 + 15, 100);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, X0 + 15 + 16 * i, Y0 + 15, 100);
    check_val("nostart_busy", int'(busy), 0);
    check_val("nostart_writes", write_cnt, 0);
    $display("capture nostart: writes=%0d", write_cnt);

    // start together with frame_start only arms; pixels while waiting are ignored
    drive(1, 1, 0, 0, 0, 0);
    check_val("arm_busy", int'(busy), 1);
    drive(0, 0, 1, X0 + 15, Y0 + 15, 9);
    drive(0, 0, 1, X0 + 31, Y0 + 15, 9);
    w0 = write_cnt; d0 = done_cnt;
    send_frame(0, 0, 0);
    check_val("uniform_writes", write_cnt - w0, 784);
    check_val("uniform_dones", done_cnt - d0, 1);
    cnt55 = 0;
    for (int i = 0; i < 28; i++) if (got_mem[i] == 55) cnt55++;
    check_val("uniform_row0_55", cnt55, 28);
    $display("capture uniform: writes=%0d dones=%0d", write_cnt - w0, done_cnt - d0);

    run_capture("gradient", 1, 0);
    check_val("gradient_addr0", got_mem[0], 255 - 103);
    check_val("gradient_addr27", got_mem[27], 255 - 23);

    run_capture("white", 3, 0);
    check_val("white_single_px", got_mem[0], 255);
    check_val("white_full_block", got_mem[3], 0);
    check_val("white_other", got_mem[5], 255);

    run_capture("random", 2, -1);

    // restart after 300 writes, with an ignored start during capture
    w0 = write_cnt; d0 = done_cnt;
    drive(1, 0, 0, 0, 0, 0);
    send_frame(2, -1, 300);
    drive(1, 0, 0, 0, 0, 0);
    check_val("restart_busy", int'(busy), 1);
    send_frame(2, -1, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    check_val("restart_writes", write_cnt - w0, 1084);
    check_val("restart_dones", done_cnt - d0, 1);
    check_val("restart_busy_end", int'(busy), 0);
    $display("capture restart: writes=%0d dones=%0d", write_cnt - w0, done_cnt - d0);

    // reset in the middle of a capture
    drive(1, 0, 0, 0, 0, 0);
    send_frame(2, -1, 150);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_state = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    w0 = write_cnt;
    for (int i = 0; i < 8; i++) drive(0, 0, 1, X0 + 15 + 16 * i, Y0 + 175, 50);
    check_val("postreset_writes", write_cnt - w0, 0);
    run_capture("after_reset", 2, -1);

    check_val("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
